// File: rtl/piso_share_pkg.sv
// Shared types and constants for the two-requester PISO serializer.
// Holds the FSM encoding, the requester IDs and the round-robin grant helper.
package piso_share_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        PAR   = ST_PAR
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // The pointer only breaks ties; a lone requester always wins.
    function automatic logic rr_grant(input logic v0, input logic v1, input logic ptr);
        if (v0 && v1) begin
            return ptr;
        end
        return v1 ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit parallel-load, shift-left register; msb is the bit currently on the wire.
module piso_shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] shreg;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: this register is cleared on reset so a dropped frame never leaks stale bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/piso_share_ctrl.sv
// Round-robin arbiter + FSM sharing one serializer between two requesters.
// Define PARITY_EN to append an even-parity bit (^data) after each data word.
module piso_share_ctrl
    import piso_share_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data0,
    input  logic             valid0,
    output logic             ready0,
    input  logic [WIDTH-1:0] data1,
    input  logic             valid1,
    output logic             ready1,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             ser_src,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rr_ptr;
    logic             grant;
    logic             xfer;
    logic             shift_en;
    logic             msb;
    logic [WIDTH-1:0] load_data;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant     = rr_grant(valid0, valid1, rr_ptr);
        ready0    = 1'b0;
        ready1    = 1'b0;
        load_data = data0;
        // Gating with reset keeps ready low while the block is held in reset.
        if (reset && state == IDLE) begin
            ready0 = valid0 && (grant == REQ0);
            ready1 = valid1 && (grant == REQ1);
        end
        if (grant == REQ1) begin
            load_data = data1;
        end
        xfer     = ready0 || ready1;
        shift_en = (state == SHIFT);
    end

    piso_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (xfer),
        .shift (shift_en),
        .data  (load_data),
        .msb   (msb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= REQ0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            ser_src   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        state     <= SHIFT;
                        cnt       <= CNT_W'(WIDTH - 1);
                        rr_ptr    <= ~grant;
                        ser_valid <= 1'b1;
                        ser_last  <= 1'b0;
                        ser_src   <= grant;
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
`ifdef PARITY_EN
                        state    <= PAR;
                        ser_last <= 1'b1;
`else
                        state     <= IDLE;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                        ser_src   <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
`ifdef PARITY_EN
                        ser_last <= 1'b0;
`else
                        ser_last <= (cnt == CNT_W'(1));
`endif
                    end
                end
                PAR: begin
                    state     <= IDLE;
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                    ser_src   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                    ser_src   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PARITY_EN
    logic par_bit;

    // Parity is taken from the word as loaded, before shifting destroys it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit <= 1'b0;
        end else if (xfer) begin
            par_bit <= ^load_data;
        end
    end

    assign ser_out = ser_valid && ((state == PAR) ? par_bit : msb);
`else
    assign ser_out = ser_valid && msb;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_piso_share_ctrl.sv
// Self-checking bench for piso_share_ctrl: queue-based frame model plus directed literal checks.
module tb_piso_share_ctrl;

    localparam int WIDTH = 4;
`ifdef PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam int FL = WIDTH + (PAR_ON ? 1 : 0);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] data0 = '0;
    logic             valid0 = 1'b0;
    logic             ready0;
    logic [WIDTH-1:0] data1 = '0;
    logic             valid1 = 1'b0;
    logic             ready1;
    logic             ser_out, ser_valid, ser_last, ser_src, busy;

    piso_share_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .data0     (data0),
        .valid0    (valid0),
        .ready0    (ready0),
        .data1     (data1),
        .valid1    (valid1),
        .ready1    (ready1),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .ser_src   (ser_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the expected output stream is a queue of bits; empty queue means idle.
    typedef struct packed {
        logic b;
        logic last;
        logic src;
    } sbit_t;

    sbit_t q[$];
    logic  rr = 1'b0;
    logic  took0 = 1'b0;
    logic  took1 = 1'b0;
    bit    rand_mode = 1'b0;

    function automatic logic model_grant(input logic v0, input logic v1);
        if (v0 && v1) return rr;
        return v1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            took0 = 1'b0;
            took1 = 1'b0;
            if (reset) begin
                if (q.size() != 0) begin
                    void'(q.pop_front());
                end else if (valid0 || valid1) begin
                    logic             g;
                    logic [WIDTH-1:0] d;
                    g = model_grant(valid0, valid1);
                    d = g ? data1 : data0;
                    for (int i = WIDTH - 1; i >= 0; i--) begin
                        q.push_back('{b: d[i], last: (i == 0) && !PAR_ON, src: g});
                    end
                    if (PAR_ON) q.push_back('{b: ^d, last: 1'b1, src: g});
                    rr = ~g;
                    if (g) took1 = 1'b1; else took0 = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge reset);
            q.delete();
            rr = 1'b0;
        end
    end

    // Compare process: every output, every cycle, against the model.
    initial begin
        forever begin
            @(negedge clk);
            begin
                sbit_t e;
                logic  ev, idle, g;
                ev   = (q.size() != 0);
                e    = ev ? q[0] : '0;
                idle = reset && !ev;
                g    = model_grant(valid0, valid1);
                check("m_ser_valid", ser_valid, ev);
                check("m_ser_out", ser_out, e.b);
                check("m_ser_last", ser_last, e.last);
                check("m_ser_src", ser_src, e.src);
                check("m_busy", busy, ev);
                check("m_ready0", ready0, idle && valid0 && !g);
                check("m_ready1", ready1, idle && valid1 && g);
            end
        end
    end

    // Random requesters: hold each word until taken, then maybe offer a new one.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                if (took0 || !valid0) begin
                    valid0 = ($urandom_range(0, 2) != 0);
                    data0  = WIDTH'($urandom);
                end
                if (took1 || !valid1) begin
                    valid1 = ($urandom_range(0, 2) != 0);
                    data1  = WIDTH'($urandom);
                end
                if ($urandom_range(0, 149) == 0) begin
                    #1 reset = 1'b0;
                    @(posedge clk);
                    #1 reset = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_lit(input string nm, input logic [4:0] bits, input int len, input logic src);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check({nm, "_out"}, ser_out, bits[len-1-i]);
            check({nm, "_valid"}, ser_valid, 1'b1);
            check({nm, "_last"}, ser_last, (i == len - 1));
            check({nm, "_src"}, ser_src, src);
        end
        @(negedge clk);
        check({nm, "_gap_busy"}, busy, 1'b0);
    endtask

    initial begin
        // Tests 1+2: reset low between edges, release with a pending word.
        valid0 = 1'b1;
        data0  = 4'b1010;
        #3;
        check("t1_ready0_rst", ready0, 1'b0);
        check("t1_outs_rst", {ser_out, ser_valid, ser_last, ser_src, busy, ready1}, 6'b0);
        step();
        reset = 1'b1;
        #1;
        check("t1_ready0_rel", ready0, 1'b1);
        step();
        valid0 = 1'b0;
        frame_lit("t2", PAR_ON ? 5'b10100 : 5'b01010, FL, 1'b0);

        // Test 3: both requesters held valid from reset alternate 0,1,0.
        step();
        reset  = 1'b0;
        valid0 = 1'b1; data0 = 4'b0011;
        valid1 = 1'b1; data1 = 4'b0110;
        step();
        reset = 1'b1;
        begin
            logic [WIDTH-1:0] words[3];
            logic             srcs[3];
            logic [WIDTH-1:0] w;
            int               nf, idx;
            nf = 0; idx = 0; w = '0;
            for (int c = 0; c < 60 && nf < 3; c++) begin
                @(negedge clk);
                if (ser_valid) begin
                    if (idx < WIDTH) w = {w[WIDTH-2:0], ser_out};
                    idx++;
                    if (ser_last) begin
                        words[nf] = w;
                        srcs[nf]  = ser_src;
                        nf++;
                        idx = 0;
                    end
                end
            end
            check("t3_frames", nf, 3);
            if (nf == 3) begin
                check("t3_w0", words[0], 4'b0011);
                check("t3_s0", srcs[0], 1'b0);
                check("t3_w1", words[1], 4'b0110);
                check("t3_s1", srcs[1], 1'b1);
                check("t3_w2", words[2], 4'b0011);
                check("t3_s2", srcs[2], 1'b0);
            end
        end

        // Test 4: valid1 rises mid-frame and must wait for IDLE.
        step();
        reset  = 1'b0;
        valid1 = 1'b0;
        valid0 = 1'b1; data0 = 4'b1100;
        step();
        reset = 1'b1;
        step();
        valid0 = 1'b0;
        step();
        valid1 = 1'b1; data1 = 4'b1001;
        for (int i = 0; i < FL - 1; i++) begin
            @(negedge clk);
            check("t4_ready1_wait", ready1, 1'b0);
        end
        @(negedge clk);
        check("t4_ready1_idle", ready1, 1'b1);
        check("t4_busy_idle", busy, 1'b0);
        step();
        valid1 = 1'b0;
        @(negedge clk);
        check("t4_src1", {ser_valid, ser_src}, 2'b11);
        repeat (FL + 1) step();

        // Test 5: reset mid-frame drops it; the pending word restarts in full.
        reset  = 1'b0;
        valid0 = 1'b1; data0 = 4'b1111;
        step();
        reset = 1'b1;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        check("t5_valid_drop", ser_valid, 1'b0);
        check("t5_busy_drop", busy, 1'b0);
        step();
        reset = 1'b1;
        #1;
        check("t5_ready0_again", ready0, 1'b1);
        step();
        valid0 = 1'b0;
        frame_lit("t5", PAR_ON ? 5'b11110 : 5'b01111, FL, 1'b0);

        // Test 6: lone requester 1 with 0111 (parity 1 when enabled).
        step();
        reset  = 1'b0;
        valid1 = 1'b1; data1 = 4'b0111;
        step();
        reset = 1'b1;
        #1;
        check("t6_ready1", ready1, 1'b1);
        step();
        valid1 = 1'b0;
        frame_lit("t6", PAR_ON ? 5'b01111 : 5'b00111, FL, 1'b1);

        // Randomized traffic with occasional async resets.
        rand_mode = 1'b1;
        repeat (3000) @(posedge clk);
        rand_mode = 1'b0;
        #1;
        reset  = 1'b1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        repeat (FL + 3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
